// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: default byte width,
// arbiter state encoding and a constant-evaluable clog2 helper.
package uart_pkg;

    localparam int D_BIT_DEF = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Plain-vector state constants for modules that keep state as logic.
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_OWN  = OWN;

    // Ceiling log2 with a floor of 1 so that every index/counter has a bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: returns the first asserted request
// found when scanning ptr, ptr+1, ... modulo N_REQ.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    logic [IDX_W:0]   sum_w  [N_REQ];
    logic [IDX_W-1:0] cand_w [N_REQ];
    logic [N_REQ-1:0] hit_w;

    // Candidate gi is the requester visited at scan step gi.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign sum_w[gi]  = {1'b0, ptr} + (IDX_W + 1)'(gi);
            assign cand_w[gi] = (sum_w[gi] >= (IDX_W + 1)'(N_REQ))
                              ? IDX_W'(sum_w[gi] - (IDX_W + 1)'(N_REQ))
                              : sum_w[gi][IDX_W-1:0];
            assign hit_w[gi]  = req[cand_w[gi]];
        end
    endgenerate

    // Walk from the last scan step down so the earliest step wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (hit_w[i]) begin
                winner = cand_w[i];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART tx FIFO write port.
// Define UART_TX_ARB_PRIO_EN to give requester 0 fixed priority at arbitration.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int D_BIT   = D_BIT_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*D_BIT-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       grant,
    input  logic                   tx_full,
    output logic [D_BIT-1:0]       w_data,
    output logic                   wr
);

    localparam int IDX_W = clog2(N_REQ);
    localparam int CNT_W = clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;

    logic [D_BIT-1:0] slice_w [N_REQ];
    logic [IDX_W-1:0] pick_idx_w;
    logic             pick_found_w;
    logic [IDX_W-1:0] win_idx_w;
    logic [N_REQ-1:0] win_onehot_w;
    logic [IDX_W-1:0] owner_inc_w;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign slice_w[gi] = req_data[gi*D_BIT +: D_BIT];
        end
    endgenerate

    uart_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_idx_w),
        .found  (pick_found_w)
    );

`ifdef UART_TX_ARB_PRIO_EN
    // Requester 0 jumps the queue, but only when nobody owns the port.
    assign win_idx_w = req[0] ? '0 : pick_idx_w;
`else
    assign win_idx_w = pick_idx_w;
`endif

    assign win_onehot_w = {{(N_REQ - 1){1'b0}}, 1'b1} << win_idx_w;
    assign owner_inc_w  = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    assign grant        = grant_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        idle_cnt_d = idle_cnt_q;
        grant_d    = grant_q;
        wr         = 1'b0;
        ack        = '0;
        w_data     = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found_w) begin
                    owner_d    = win_idx_w;
                    grant_d    = win_onehot_w;
                    idle_cnt_d = '0;
                    state_d    = ST_OWN;
                end
            end
            default: begin
                w_data       = slice_w[owner_q];
                wr           = req[owner_q] & ~tx_full;
                ack[owner_q] = wr;
                if (wr) begin
                    idle_cnt_d = '0;
                    if (req_last[owner_q]) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = owner_inc_w;
                    end
                end else if (!req[owner_q]) begin
                    // A stalled owner (full FIFO) keeps its count frozen.
                    if (idle_cnt_q == CNT_MAX) begin
                        idle_cnt_d = '0;
                        state_d    = ST_IDLE;
                        grant_d    = '0;
                        ptr_d      = owner_inc_w;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            idle_cnt_q <= '0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            idle_cnt_q <= idle_cnt_d;
            grant_q    <= grant_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter (2-requester and 3-requester builds).
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: N_REQ=2, TIMEOUT=16
    logic [1:0]  req_a = '0;
    logic [15:0] req_data_a = '0;
    logic [1:0]  req_last_a = '0;
    logic [1:0]  ack_a;
    logic [1:0]  grant_a;
    logic        tx_full_a = 1'b0;
    logic [7:0]  w_data_a;
    logic        wr_a;

    // Instance B: N_REQ=3, TIMEOUT=4
    logic [2:0]  req_b = '0;
    logic [23:0] req_data_b = '0;
    logic [2:0]  req_last_b = '0;
    logic [2:0]  ack_b;
    logic [2:0]  grant_b;
    logic        tx_full_b = 1'b0;
    logic [7:0]  w_data_b;
    logic        wr_b;

    uart_tx_arbiter #(.N_REQ(2), .D_BIT(8), .TIMEOUT(16)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .req_data(req_data_a),
        .req_last(req_last_a), .ack(ack_a), .grant(grant_a),
        .tx_full(tx_full_a), .w_data(w_data_a), .wr(wr_a)
    );

    uart_tx_arbiter #(.N_REQ(3), .D_BIT(8), .TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .req_data(req_data_b),
        .req_last(req_last_b), .ack(ack_b), .grant(grant_b),
        .tx_full(tx_full_b), .w_data(w_data_b), .wr(wr_b)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic [8:0]  src0_q[$];   // {last, byte} per requester
    logic [8:0]  src1_q[$];
    logic [8:0]  exp_q[$];    // {requester id, byte} in FIFO order
    logic [15:0] wr_hist;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a();
        logic [8:0] h0;
        logic [8:0] h1;
        h0 = (src0_q.size() != 0) ? src0_q[0] : 9'h000;
        h1 = (src1_q.size() != 0) ? src1_q[0] : 9'h000;
        req_a      = {src1_q.size() != 0, src0_q.size() != 0};
        req_data_a = {h1[7:0], h0[7:0]};
        req_last_a = {h1[8], h0[8]};
        #1;
    endtask

    // One clock of instance A: score any write, then advance requesters on ack.
    task automatic cycle_a();
        logic       acc0;
        logic       acc1;
        logic [8:0] e;
        wr_hist = {wr_hist[14:0], wr_a};
        if (wr_a === 1'b1) begin
            n_total++;
            assert (exp_q.size() != 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL unexpected_wr: observed w_data=%0h expected no write", w_data_a);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_w_data", {24'h0, w_data_a}, {24'h0, e[7:0]});
                check("sb_ack", {30'h0, ack_a}, 32'd1 << e[8]);
            end
        end else begin
            check("ack_without_wr", {30'h0, ack_a}, 32'h0);
        end
        acc0 = ack_a[0];
        acc1 = ack_a[1];
        @(posedge clk);
        #1;
        if (acc0 && src0_q.size() != 0) void'(src0_q.pop_front());
        if (acc1 && src1_q.size() != 0) void'(src1_q.pop_front());
        drive_a();
    endtask

    task automatic tick_b();
        @(posedge clk);
        #2;
    endtask

    initial begin
        wr_hist = '0;
        #2;
        check("rst_grant_a", {30'h0, grant_a}, 32'h0);
        check("rst_wr_a", {31'h0, wr_a}, 32'h0);
        check("rst_ack_a", {30'h0, ack_a}, 32'h0);
        check("rst_wdata_a", {24'h0, w_data_a}, 32'h0);
        check("rst_grant_b", {29'h0, grant_b}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive_a();

        // Reset mid-packet: two bytes out, third pending
        src0_q.push_back({1'b0, 8'h11});
        src0_q.push_back({1'b0, 8'h12});
        src0_q.push_back({1'b0, 8'h13});
        src0_q.push_back({1'b1, 8'h14});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h12});
        drive_a();
        repeat (3) cycle_a();
        check("pre_reset_wr", {31'h0, wr_a}, 32'h1);
        reset = 1'b1;
        #1;
        check("async_rst_grant", {30'h0, grant_a}, 32'h0);
        check("async_rst_wr", {31'h0, wr_a}, 32'h0);
        check("async_rst_ack", {30'h0, ack_a}, 32'h0);
        src0_q.delete();
        drive_a();
        @(negedge clk);
        reset = 1'b0;
        src1_q.push_back({1'b1, 8'h21});
        exp_q.push_back({1'b1, 8'h21});
        drive_a();
        check("grant_before_arb", {30'h0, grant_a}, 32'h0);
        cycle_a();
        check("grant_after_reset", {30'h0, grant_a}, 32'h2);
        cycle_a();
        check("release_after_last", {30'h0, grant_a}, 32'h0);

        // Round-robin with 3-byte packets on both requesters
        for (int p = 0; p < 2; p++) begin
            src0_q.push_back({1'b0, 8'hA1});
            src0_q.push_back({1'b0, 8'hA2});
            src0_q.push_back({1'b1, 8'hA3});
            src1_q.push_back({1'b0, 8'hB1});
            src1_q.push_back({1'b0, 8'hB2});
            src1_q.push_back({1'b1, 8'hB3});
            exp_q.push_back({1'b0, 8'hA1});
            exp_q.push_back({1'b0, 8'hA2});
            exp_q.push_back({1'b0, 8'hA3});
            exp_q.push_back({1'b1, 8'hB1});
            exp_q.push_back({1'b1, 8'hB2});
            exp_q.push_back({1'b1, 8'hB3});
        end
        drive_a();
        wr_hist = '0;
        repeat (16) cycle_a();
        check("rr_wr_pattern", {16'h0, wr_hist}, 32'h7777);
        check("rr_sb_drained", exp_q.size(), 32'h0);

        // Backpressure mid-packet: a full FIFO must not time the owner out
        src0_q.push_back({1'b0, 8'hC1});
        src0_q.push_back({1'b0, 8'hC2});
        src0_q.push_back({1'b1, 8'hC3});
        exp_q.push_back({1'b0, 8'hC1});
        exp_q.push_back({1'b0, 8'hC2});
        exp_q.push_back({1'b0, 8'hC3});
        drive_a();
        cycle_a();
        cycle_a();
        tx_full_a = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            check("stall_wr", {31'h0, wr_a}, 32'h0);
            check("stall_wdata", {24'h0, w_data_a}, 32'hC2);
            cycle_a();
        end
        check("stall_no_timeout", {30'h0, grant_a}, 32'h1);
        tx_full_a = 1'b0;
        #1;
        check("unstall_wr", {31'h0, wr_a}, 32'h1);
        cycle_a();
        cycle_a();
        check("bp_release", {30'h0, grant_a}, 32'h0);

        // Idle timeout: requester 1 abandons its packet, requester 0 waits
        src1_q.push_back({1'b0, 8'hD1});
        src0_q.push_back({1'b1, 8'hE1});
        exp_q.push_back({1'b1, 8'hD1});
        exp_q.push_back({1'b0, 8'hE1});
        drive_a();
        cycle_a();
        check("to_grant", {30'h0, grant_a}, 32'h2);
        cycle_a();
        for (int i = 0; i < 15; i++) begin
            check("to_wait_wr", {31'h0, wr_a}, 32'h0);
            cycle_a();
        end
        check("to_hold", {30'h0, grant_a}, 32'h2);
        cycle_a();
        check("to_revoke", {30'h0, grant_a}, 32'h0);
        cycle_a();
        check("to_next_grant", {30'h0, grant_a}, 32'h1);
        cycle_a();
        check("to_done", {30'h0, grant_a}, 32'h0);

        // Release while the other requester and the releasing one both wait
        src0_q.push_back({1'b1, 8'hF1});
        src0_q.push_back({1'b1, 8'hF2});
        exp_q.push_back({1'b0, 8'hF1});
        drive_a();
        cycle_a();
        check("sim_first_grant", {30'h0, grant_a}, 32'h1);
        src1_q.push_back({1'b1, 8'h31});
`ifdef UART_TX_ARB_PRIO_EN
        exp_q.push_back({1'b0, 8'hF2});
        exp_q.push_back({1'b1, 8'h31});
`else
        exp_q.push_back({1'b1, 8'h31});
        exp_q.push_back({1'b0, 8'hF2});
`endif
        drive_a();
        cycle_a();
        cycle_a();
`ifdef UART_TX_ARB_PRIO_EN
        check("sim_next_grant", {30'h0, grant_a}, 32'h1);
`else
        check("sim_next_grant", {30'h0, grant_a}, 32'h2);
`endif
        repeat (3) cycle_a();
        check("sim_done", {30'h0, grant_a}, 32'h0);
        check("sb_drained", exp_q.size(), 32'h0);

        // Three requesters, single-byte packets, all always requesting
        req_b      = 3'b111;
        req_last_b = 3'b111;
        req_data_b = {8'hC2, 8'hC1, 8'hC0};
        #1;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = i % 3;
            tick_b();
            check("b_grant", {29'h0, grant_b}, 32'd1 << k);
            check("b_wr", {31'h0, wr_b}, 32'h1);
            check("b_wdata", {24'h0, w_data_b}, 32'hC0 + k);
            check("b_ack", {29'h0, ack_b}, 32'd1 << k);
            tick_b();
            check("b_idle_grant", {29'h0, grant_b}, 32'h0);
            check("b_idle_wr", {31'h0, wr_b}, 32'h0);
        end
        req_b = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO write port (w_data/wr, gated by tx_full) among N_REQ byte-stream requesters, e.g. the rx→tx echo path, a status-message generator and a debug dumper.
- Arbitration is round-robin at packet granularity: the winner owns the FIFO until it sends a byte flagged last, or until an idle timeout expires.
- Sits between the requesters and the tx FIFO write side.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- D_BIT, 8, data byte width.
- TIMEOUT, 16, consecutive cycles with the owner's req low before ownership is revoked (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester valid: byte available on its req_data slice.
- req_data  input  N_REQ*D_BIT  packed bytes; requester k uses bits [k*D_BIT +: D_BIT].
- req_last  input  N_REQ  current byte of requester k ends its packet.
- ack  output  N_REQ  one-hot or zero: byte of requester k accepted this cycle.
- grant  output  N_REQ  one-hot or zero: current owner, registered.
- tx_full  input  1  tx FIFO full.
- w_data  output  D_BIT  byte to tx FIFO.
- wr  output  1  tx FIFO write strobe, one cycle per byte.

Behaviour:
- State register: IDLE, OWN. Also registered: owner index, rr pointer ptr, idle_cnt (width clog2(TIMEOUT)).
- Reset (async, any state, including mid-packet): state=IDLE, ptr=0, owner=0, idle_cnt=0, grant=0. Outputs wr=0, ack=0, w_data=0.
- IDLE:
  - If any req is high, choose the first set req scanning ptr, ptr+1, … modulo N_REQ.
  - Next edge: owner<=winner, grant<=onehot(winner), idle_cnt<=0, state<=OWN.
  - No write occurs in IDLE. Arbitration latency is 1 cycle from req to grant.
- OWN:
  - Combinational outputs: wr = req[owner] & ~tx_full; ack[owner] = wr, all other ack bits 0; w_data = req_data slice of owner.
  - When wr=0, w_data is held at the owner's slice. It is don't-care for the FIFO.
  - Accepted byte (wr=1): idle_cnt<=0.
    - If req_last[owner]=1: state<=IDLE, grant<=0, ptr<=(owner+1) mod N_REQ.
  - Stall (req[owner]=1, tx_full=1): no write, ack=0. idle_cnt is unchanged; a full FIFO never causes timeout.
  - Owner idle (req[owner]=0): idle_cnt++. When idle_cnt reaches TIMEOUT-1: state<=IDLE, grant<=0, ptr<=(owner+1) mod N_REQ. The packet is abandoned, with no FIFO write.
- Requesters must hold req/req_data/req_last stable until ack. They may change them the cycle after ack.
- Non-owner reqs are ignored during OWN, with no ack.
- Back-to-back packets: after release there is one IDLE cycle before the next grant, so maximum throughput is 1 byte/cycle within a packet.
- A single-byte packet with req_last=1 on the first beat takes 1 OWN cycle if not full.
- ptr wraps from N_REQ-1 to 0.

Optional Feature:
- Macro: UART_TX_ARB_PRIO_EN.
- Defined: requester 0 has fixed top priority in IDLE and wins whenever req[0]=1, regardless of ptr. The other requesters are ordered round-robin as usual. Ownership is still packet-locked: requester 0 never pre-empts an owner mid-packet.
- Undefined: pure round-robin, as above.

Decomposition:
- Shared package uart_pkg: D_BIT default constant; state enum {IDLE, OWN}; a clog2 helper function.
- One natural sub-module: uart_rr_picker. It is combinational: inputs req vector and ptr; outputs winner index and a found flag. It is parameterized by N_REQ and instantiated once.

Test Plan:
- Reset mid-packet: req0 owns with 2 bytes sent, assert reset → grant=0, wr=0 immediately (async). After release, req1=1 alone → grant=2'b10 one cycle later.
- Round-robin: req=2'b11 continuously, each requester sends 3-byte packets (0xA1,0xA2,0xA3 / 0xB1,0xB2,0xB3) → FIFO sees A1 A2 A3 B1 B2 B3 A1 …, with one idle cycle between packets.
- Backpressure: tx_full=1 for 5 cycles mid-packet → wr=0, ack=0, byte held. No timeout with TIMEOUT=4. Byte written on the first cycle tx_full=0.
- Timeout: owner drops req after 1 byte with TIMEOUT=16 → grant cleared after 16 idle cycles. The other waiting requester is granted next cycle.
- Simultaneous release and new request: req0 last byte accepted while req1 and req0 are high → next grant goes to req1 (ptr=1). With UART_TX_ARB_PRIO_EN defined → grant goes to req0.
- Single-byte packets with N_REQ=3, all req high, req_last=1 → grants 001,010,100,001 in order, ptr wrapping to 0.
